// File: rtl/mux_scan_ctrl_if.sv
// Bus between a requester and mux_scan_ctrl: request fields, the selected
// mux output, the mux selects and the capture results.
interface mux_scan_ctrl_if;
    logic       start;
    logic       mode;
    logic [1:0] chan;
    logic       e;
    logic       s1;
    logic       s2;
    logic       busy;
    logic       done;
    logic [3:0] sample;
    logic [3:0] valid_mask;

    // Requester side: issues requests and presents the downstream mux output.
    modport master (
        output start, mode, chan, e,
        input  s1, s2, busy, done, sample, valid_mask
    );

    // Controller side.
    modport slave (
        input  start, mode, chan, e,
        output s1, s2, busy, done, sample, valid_mask
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives the selects of a downstream 4-to-1 mux, waits DWELL
// settle cycles per channel, then captures the mux output into sample[].
// Scan mode visits channels 0..3 in order; single mode visits one channel.
module mux_scan_ctrl #(
    parameter int DWELL = 2
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // The counter is reloaded with DWELL-1 and counts down to zero, which
    // gives exactly DWELL cycles in SETTLE.
    localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_mode;
    logic [1:0] r_sel;    // current channel; in single mode it also holds the latched chan
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_sample;
    logic [3:0] r_valid;

    // Sequencer: state, select, dwell counter and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_mode   <= 1'b0;
            r_sel    <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sample <= 4'b0000;
            r_valid  <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mode   <= bus.mode;
                        r_sel    <= bus.mode ? bus.chan : 2'b00;
                        r_sample <= 4'b0000;
                        r_valid  <= 4'b0000;
                        r_cnt    <= DWELL_M1;
                        r_busy   <= 1'b1;
                        r_state  <= SETTLE;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    r_sample[r_sel] <= bus.e;
                    r_valid[r_sel]  <= 1'b1;
                    if (!r_mode && (r_sel != 2'b11)) begin
                        r_sel   <= r_sel + 2'd1;
                        r_cnt   <= DWELL_M1;
                        r_state <= SETTLE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s1         = r_sel[1];
    assign bus.s2         = r_sel[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sample     = r_sample;
    assign bus.valid_mask = r_valid;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl (DWELL=2). A behavioural 4-to-1 mux with
// inputs a=0, b=1, c=0, d=1 feeds e from the DUT selects.
module tb_mux_scan_ctrl;
    logic clk;
    logic rst;
    logic [3:0] mux_in;
    int n_checks;
    int n_fail;

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(.DWELL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Downstream mux: bit i of mux_in is channel i (d,c,b,a = 1,0,1,0).
    assign mux_in = 4'b1010;
    assign bus.e  = mux_in[{bus.s1, bus.s2}];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] sel, input logic busy,
                           input logic done, input logic [3:0] smp, input logic [3:0] vm);
        chk({tag, "_sel"},    {30'd0, bus.s1, bus.s2}, {30'd0, sel});
        chk({tag, "_busy"},   {31'd0, bus.busy},       {31'd0, busy});
        chk({tag, "_done"},   {31'd0, bus.done},       {31'd0, done});
        chk({tag, "_sample"}, {28'd0, bus.sample},     {28'd0, smp});
        chk({tag, "_valid"},  {28'd0, bus.valid_mask}, {28'd0, vm});
    endtask

    // Checks cycles 1..13 of a scan already started; optionally pulses start
    // in cycle inj_cyc. Leaves the bench in cycle 14.
    task automatic run_scan(input string tag, input int inj_cyc);
        int ncap;
        logic [1:0] esel;
        logic [3:0] evm;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 12) begin
                ncap = (c - 1) / 3;
                esel = 2'((c - 1) / 3);
            end else begin
                ncap = 4;
                esel = 2'b11;
            end
            evm = 4'((1 << ncap) - 1);
            chk_all($sformatf("%s_c%0d", tag, c), esel, (c <= 12), (c == 13),
                    evm & 4'b1010, evm);
            bus.start = (c == inj_cyc) ? 1'b1 : 1'b0;
            step();
            bus.start = 1'b0;
        end
    endtask

    // Linear directed sequence.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.chan  = 2'b00;
        step();
        step();

        // Reset state, with start asserted together with reset.
        bus.start = 1'b1;
        step();
        chk_all("reset", 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0000);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        chk_all("rst_start_ignored", 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Full scan; mode/chan disturbed right after acceptance.
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        step();
        bus.start = 1'b0;
        bus.mode  = 1'b1;
        bus.chan  = 2'b10;
        run_scan("scan", 0);
        chk_all("scan_hold1", 2'b11, 1'b0, 1'b0, 4'b1010, 4'b1111);
        step();
        chk_all("scan_hold2", 2'b11, 1'b0, 1'b0, 4'b1010, 4'b1111);

        // Single channel 01; chan changed after acceptance.
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.chan  = 2'b01;
        step();
        bus.start = 1'b0;
        bus.chan  = 2'b11;
        bus.mode  = 1'b0;
        chk_all("single_c1", 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0000);
        step();
        chk_all("single_c2", 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0000);
        step();
        chk_all("single_c3", 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0000);
        step();
        chk_all("single_c4", 2'b01, 1'b0, 1'b1, 4'b0010, 4'b0010);

        // Start during DONE is ignored; held into the next cycle it is accepted.
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        step();
        chk_all("done_start_ignored", 2'b01, 1'b0, 1'b0, 4'b0010, 4'b0010);
        step();
        bus.start = 1'b0;
        // Back-to-back scan with an extra start pulse in cycle 5.
        run_scan("b2b", 5);
        chk_all("b2b_no_restart", 2'b11, 1'b0, 1'b0, 4'b1010, 4'b1111);

        // Reset mid-scan in cycle 6.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        chk_all("pre_rst_c6", 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_mid", 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0000);
        for (int c = 0; c < 10; c++) begin
            step();
            chk({"rst_mid_nodone"}, {31'd0, bus.done}, 32'd0);
            chk({"rst_mid_idle"},   {28'd0, bus.valid_mask}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
